// File: rtl/cop0_exception_unit_pkg.sv
// Shared definitions for the coprocessor-0 exception unit: register numbers,
// exception codes and the prioritizer result bundle.
package cop0_exception_unit_pkg;

    localparam logic [4:0] COP0_STATUS = 5'd12;
    localparam logic [4:0] COP0_CAUSE  = 5'd13;
    localparam logic [4:0] COP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [4:0]  exc_code;
    } exc_req_t;

endpackage

// File: rtl/cop0_exc_prioritizer.sv
// Combinational priority encoder: picks the highest-priority qualified request
// and the PC/ExcCode that go with it.
module cop0_exc_prioritizer
    import cop0_exception_unit_pkg::*;
(
    input  logic        overflow,
    input  logic        illegal,
    input  logic        interrupt,
    input  logic        ie,
    input  logic        exl,
    input  logic [31:0] pc_execute,
    input  logic [31:0] pc_decode,
    input  logic [31:0] pc_fetch,
    output exc_req_t    req
);

    always_comb begin
        req = '{taken: 1'b0, pc: 32'h0, exc_code: EXC_INT};
        // EXL masks everything; masked requests are simply dropped.
        if (!exl) begin
            if (overflow) begin
                req = '{taken: 1'b1, pc: pc_execute, exc_code: EXC_OV};
            end else if (illegal) begin
                req = '{taken: 1'b1, pc: pc_decode, exc_code: EXC_RI};
            end else if (interrupt && ie) begin
                req = '{taken: 1'b1, pc: pc_fetch, exc_code: EXC_INT};
            end
        end
    end

endmodule

// File: rtl/cop0_exception_unit.sv
// MIPS coprocessor-0: Status/Cause/EPC registers, exception entry, eret and
// mtc0/mfc0 access for the 5-stage pipeline.
module cop0_exception_unit
    import cop0_exception_unit_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter logic [31:0] STATUS_RST   = 32'h0000_0001
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_arithmetic_overflow,
    input  logic        i_unknown_command,
    input  logic        i_unknown_func,
    input  logic        i_external_interrupt,
    input  logic [31:0] i_data,
    input  logic [4:0]  i_address,
    input  logic [31:0] i_pc_to_epc_from_execute,
    input  logic [31:0] i_pc_to_epc_from_decode,
    input  logic [31:0] i_pc_to_epc_from_fetch,
    input  logic        i_mtc0,
    input  logic        i_eret,
    output logic [31:0] o_epc_to_pc,
    output logic        o_exeption,
    output logic [31:0] o_handler_address,
    output logic [31:0] o_data
);

    logic [31:0] status_q, status_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    exc_req_t    req;

    cop0_exc_prioritizer u_prioritizer (
        .overflow   (i_arithmetic_overflow),
        .illegal    (i_unknown_command | i_unknown_func),
        .interrupt  (i_external_interrupt),
        .ie         (status_q[STATUS_IE]),
        .exl        (status_q[STATUS_EXL]),
        .pc_execute (i_pc_to_epc_from_execute),
        .pc_decode  (i_pc_to_epc_from_decode),
        .pc_fetch   (i_pc_to_epc_from_fetch),
        .req        (req)
    );

    assign o_exeption        = req.taken & i_rst_n;
    assign o_epc_to_pc       = epc_q;
    assign o_handler_address = HANDLER_ADDR;

    // Order matters: mtc0 first, then eret clears EXL, then exception entry overrides all.
    always_comb begin
        status_d   = status_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (i_mtc0) begin
            unique case (i_address)
                COP0_STATUS: status_d   = i_data;
                COP0_CAUSE:  exc_code_d = i_data[6:2];
                COP0_EPC:    epc_d      = i_data;
                default: ;
            endcase
        end
        if (i_eret) begin
            status_d[STATUS_EXL] = 1'b0;
        end
        if (req.taken) begin
            status_d[STATUS_EXL] = 1'b1;
            exc_code_d           = req.exc_code;
            epc_d                = req.pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            status_q   <= STATUS_RST;
            exc_code_q <= EXC_INT;
            epc_q      <= 32'h0;
        end else begin
            status_q   <= status_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        o_data = 32'h0;
        unique case (i_address)
            COP0_STATUS: o_data = status_q;
            COP0_CAUSE:  o_data = {25'h0, exc_code_q, 2'b00};
            COP0_EPC:    o_data = epc_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cop0_exception_unit.sv
// Randomized and directed bench for cop0_exception_unit against a register-level
// reference model of Status/Cause/EPC.
module tb_cop0_exception_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ovf = 1'b0, ucmd = 1'b0, ufunc = 1'b0, irq = 1'b0;
    logic [31:0] data = '0;
    logic [4:0]  addr = '0;
    logic [31:0] pc_ex = '0, pc_de = '0, pc_fe = '0;
    logic        mtc0 = 1'b0, eret = 1'b0;
    logic [31:0] epc_to_pc, handler_address, rdata;
    logic        exc;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state
    logic [31:0] m_status;
    logic [4:0]  m_code;
    logic [31:0] m_epc;

    cop0_exception_unit dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_arithmetic_overflow    (ovf),
        .i_unknown_command        (ucmd),
        .i_unknown_func           (ufunc),
        .i_external_interrupt     (irq),
        .i_data                   (data),
        .i_address                (addr),
        .i_pc_to_epc_from_execute (pc_ex),
        .i_pc_to_epc_from_decode  (pc_de),
        .i_pc_to_epc_from_fetch   (pc_fe),
        .i_mtc0                   (mtc0),
        .i_eret                   (eret),
        .o_epc_to_pc              (epc_to_pc),
        .o_exeption               (exc),
        .o_handler_address        (handler_address),
        .o_data                   (rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_status;
            5'd13:   return {25'h0, m_code, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_status = 32'h1;
        m_code   = 5'd0;
        m_epc    = 32'h0;
    endtask

    task automatic idle();
        ovf = 0; ucmd = 0; ufunc = 0; irq = 0; mtc0 = 0; eret = 0;
    endtask

    // Inputs are set at a falling edge; check combinational outputs, then advance one clock.
    task automatic step();
        logic        take;
        logic [4:0]  code;
        logic [31:0] pc;
        #1;
        take = 1'b0; code = 5'd0; pc = 32'h0;
        if (m_status[1] == 1'b0) begin
            if (ovf) begin
                take = 1'b1; code = 5'd12; pc = pc_ex;
            end else if (ucmd || ufunc) begin
                take = 1'b1; code = 5'd10; pc = pc_de;
            end else if (irq && m_status[0]) begin
                take = 1'b1; code = 5'd0; pc = pc_fe;
            end
        end
        check_eq("exception", {31'h0, exc}, {31'h0, take});
        check_eq("mfc0", rdata, m_read(addr));
        check_eq("epc_to_pc", epc_to_pc, m_epc);
        check_eq("handler", handler_address, 32'h80);
        @(posedge clk);
        if (mtc0) begin
            case (addr)
                5'd12:   m_status = data;
                5'd13:   m_code = data[6:2];
                5'd14:   m_epc = data;
                default: ;
            endcase
        end
        if (eret) m_status[1] = 1'b0;
        if (take) begin
            m_status[1] = 1'b1;
            m_code      = code;
            m_epc       = pc;
        end
        @(negedge clk);
    endtask

    task automatic read_reg(input logic [4:0] a);
        idle();
        addr = a;
        step();
    endtask

    initial begin
        logic [4:0] pick;
        m_reset();
        idle();
        #1;
        check_eq("rst_exception", {31'h0, exc}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        read_reg(5'd12);
        read_reg(5'd13);
        read_reg(5'd14);

        // Illegal opcode from decode
        idle(); pc_de = 32'h24; ucmd = 1; addr = 5'd13; step();
        read_reg(5'd14);
        read_reg(5'd13);
        read_reg(5'd12);

        // Overflow outranks illegal funct; a second overflow under EXL is masked
        idle(); eret = 1; step();
        idle(); ovf = 1; ufunc = 1; pc_ex = 32'h10; pc_de = 32'h14; addr = 5'd14; step();
        read_reg(5'd13);
        idle(); ovf = 1; pc_ex = 32'h50; addr = 5'd14; step();
        idle(); eret = 1; step();

        // Interrupt, eret, then interrupt disabled via Status
        idle(); irq = 1; pc_fe = 32'h40; addr = 5'd14; step();
        read_reg(5'd13);
        idle(); eret = 1; step();
        read_reg(5'd12);
        idle(); mtc0 = 1; addr = 5'd12; data = 32'h0; step();
        idle(); irq = 1; pc_fe = 32'h44; addr = 5'd12; step();

        // Direct EPC write and an unmapped address
        idle(); mtc0 = 1; addr = 5'd14; data = 32'h1234; step();
        read_reg(5'd14);
        idle(); mtc0 = 1; addr = 5'd5; data = 32'hdead_beef; step();
        read_reg(5'd5);

        // Randomized traffic, including simultaneous events
        for (int i = 0; i < 400; i++) begin
            idle();
            ovf   = ($urandom_range(0, 7) == 0);
            ucmd  = ($urandom_range(0, 9) == 0);
            ufunc = ($urandom_range(0, 9) == 0);
            irq   = ($urandom_range(0, 3) == 0);
            eret  = ($urandom_range(0, 3) == 0);
            mtc0  = ($urandom_range(0, 3) == 0);
            pick  = 5'($urandom_range(0, 4));
            addr  = (pick < 5'd3) ? 5'd12 + pick : 5'($urandom);
            data  = $urandom;
            pc_ex = $urandom & 32'hffff_fffc;
            pc_de = $urandom & 32'hffff_fffc;
            pc_fe = $urandom & 32'hffff_fffc;
            step();
        end

        // Asynchronous reset while EXL is set
        idle(); mtc0 = 1; addr = 5'd12; data = 32'h3; step();
        idle(); ovf = 1; pc_ex = 32'h88; addr = 5'd12;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_eq("rst_async_exc", {31'h0, exc}, 32'h0);
        check_eq("rst_async_status", rdata, 32'h1);
        check_eq("rst_async_epc", epc_to_pc, 32'h0);
        addr = 5'd13;
        #1;
        check_eq("rst_async_cause", rdata, 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        read_reg(5'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
